// File: rtl/fetch_mem_resp_pkg.sv
// Shared types and constants for the fetch-side instruction memory responder.
package fetch_mem_resp_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h0800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_mem_array.sv
// Instruction storage: synchronous write, combinational read, no reset on contents.
module fetch_mem_array
    import fetch_mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [INSTR_W-1:0]    wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_index,
    output logic [INSTR_W-1:0]    rd_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_index];

endmodule

// File: rtl/fetch_mem_resp.sv
// Fixed-latency instruction fetch responder with stall, flush cancel and loader write port.
module fetch_mem_resp
    import fetch_mem_resp_pkg::*;
#(
    parameter int unsigned        DEPTH_LOG2 = 8,
    parameter int unsigned        LATENCY    = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [15:0]        addr,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [15:0]        wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               stall,
    output logic               done,
    output logic [INSTR_W-1:0] instr,
    output logic               err
);

    localparam int unsigned IDX_W  = DEPTH_LOG2;
    localparam int unsigned ADDR_W = DEPTH_LOG2 + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               stall_q, stall_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic [IDX_W-1:0]   rd_index;
    logic [INSTR_W-1:0] rd_data;

    // Address bits above the array index alias onto the same words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[15:ADDR_W], wr_addr[15:ADDR_W], wr_addr[0]};

    fetch_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr[IDX_W:1]),
        .wr_data  (wr_data),
        .rd_index (rd_index),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        stall_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        instr_d  = instr_q;
        rd_index = addr_q[IDX_W:1];

        case (state_q)
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Array is sampled at the edge entering RESP.
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = addr_q[0];
                    instr_d = addr_q[0] ? NOP_INSTR : rd_data;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_d = 1'b1;
                end
            end
            default: begin
                // IDLE and RESP both accept a new request; flush drops it.
                state_d  = IDLE;
                rd_index = addr[IDX_W:1];
                if (req && !flush) begin
                    addr_d = addr[ADDR_W-1:0];
                    cnt_d  = CNT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        stall_d = 1'b1;
                    end else begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = addr[0];
                        instr_d = addr[0] ? NOP_INSTR : rd_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            err_q   <= err_d;
            instr_q <= instr_d;
        end
    end

    assign stall = stall_q;
    assign done  = done_q;
    assign err   = err_q;
    assign instr = instr_q;

endmodule

// File: tb/tb_fetch_mem_resp.sv
// Directed bench for fetch_mem_resp: LATENCY=2 instance plus a LATENCY=1 instance for collision.
module tb_fetch_mem_resp;

    logic        clk;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    logic        stall, done, err;
    logic [15:0] instr;
    logic        stall1, done1, err1;
    logic [15:0] instr1;

    int total = 0;
    int bad   = 0;

    fetch_mem_resp #(.DEPTH_LOG2(8), .LATENCY(2), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall(stall), .done(done), .instr(instr), .err(err)
    );

    fetch_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1), .NOP_INSTR(16'h0800)) dut1 (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall(stall1), .done(done1), .instr(instr1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; addr = '0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #12;
        chk("rst_stall", 16'(stall), 16'h0);
        chk("rst_done",  16'(done),  16'h0);
        chk("rst_err",   16'(err),   16'h0);
        chk("rst_instr", instr,      16'h0000);
        rst = 1'b1;
        tick();

        mem_write(16'h0006, 16'hC0DE);
        mem_write(16'h0000, 16'h1111);
        mem_write(16'h0002, 16'h2222);

        // basic read
        req = 1'b1; addr = 16'h0006;
        tick();
        chk("basic_stall_c1", 16'(stall), 16'h1);
        chk("basic_done_c1",  16'(done),  16'h0);
        req = 1'b0;
        tick();
        chk("basic_done_c2",  16'(done),  16'h1);
        chk("basic_instr_c2", instr,      16'hC0DE);
        chk("basic_err_c2",   16'(err),   16'h0);
        chk("basic_stall_c2", 16'(stall), 16'h0);
        tick();
        chk("basic_done_c3",  16'(done),  16'h0);
        chk("basic_hold_c3",  instr,      16'hC0DE);

        // back-to-back with req held
        req = 1'b1; addr = 16'h0000;
        tick();
        chk("b2b_stall_c1", 16'(stall), 16'h1);
        addr = 16'h0002;
        tick();
        chk("b2b_done_c2",  16'(done),  16'h1);
        chk("b2b_instr_c2", instr,      16'h1111);
        chk("b2b_stall_c2", 16'(stall), 16'h0);
        tick();
        chk("b2b_stall_c3", 16'(stall), 16'h1);
        chk("b2b_done_c3",  16'(done),  16'h0);
        req = 1'b0;
        tick();
        chk("b2b_done_c4",  16'(done),  16'h1);
        chk("b2b_instr_c4", instr,      16'h2222);
        chk("b2b_stall_c4", 16'(stall), 16'h0);
        tick();

        // misaligned then aligned
        req = 1'b1; addr = 16'h0005;
        tick();
        req = 1'b0;
        tick();
        chk("mis_done",  16'(done), 16'h1);
        chk("mis_err",   16'(err),  16'h1);
        chk("mis_instr", instr,     16'h0800);
        req = 1'b1; addr = 16'h0000;
        tick();
        chk("mis_next_err_c1", 16'(err), 16'h0);
        req = 1'b0;
        tick();
        chk("al_done",  16'(done), 16'h1);
        chk("al_err",   16'(err),  16'h0);
        chk("al_instr", instr,     16'h1111);
        tick();

        // flush during WAIT
        req = 1'b1; addr = 16'h0006;
        tick();
        chk("fl_stall_c1", 16'(stall), 16'h1);
        req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_stall_c2", 16'(stall), 16'h0);
        chk("fl_done_c2",  16'(done),  16'h0);
        chk("fl_instr_c2", instr,      16'h1111);
        tick();
        chk("fl_done_c3",  16'(done),  16'h0);
        chk("fl_instr_c3", instr,      16'h1111);

        // flush in IDLE drops a same-cycle request
        req = 1'b1; flush = 1'b1; addr = 16'h0006;
        tick();
        req = 1'b0; flush = 1'b0;
        chk("fli_stall", 16'(stall), 16'h0);
        tick();
        chk("fli_done",  16'(done),  16'h0);

        // async reset mid-WAIT
        req = 1'b1; addr = 16'h0006;
        tick();
        req = 1'b0;
        chk("ar_stall_pre", 16'(stall), 16'h1);
        #1 rst = 1'b0;
        #1;
        chk("ar_stall", 16'(stall), 16'h0);
        chk("ar_done",  16'(done),  16'h0);
        chk("ar_err",   16'(err),   16'h0);
        chk("ar_instr", instr,      16'h0000);
        #3 rst = 1'b1;
        tick();
        chk("ar_nodone", 16'(done), 16'h0);
        req = 1'b1; addr = 16'h0002;
        tick();
        req = 1'b0;
        tick();
        chk("ar_post_done",  16'(done), 16'h1);
        chk("ar_post_instr", instr,     16'h2222);
        tick();

        // wrap-around aliasing
        req = 1'b1; addr = 16'h0206;
        tick();
        req = 1'b0;
        tick();
        chk("wrap_done",  16'(done), 16'h1);
        chk("wrap_instr", instr,     16'hC0DE);
        tick();
        tick();

        // LATENCY=1 collision: write in acceptance cycle returns old data
        req = 1'b1; addr = 16'h0006;
        wr_en = 1'b1; wr_addr = 16'h0006; wr_data = 16'hBEEF;
        tick();
        req = 1'b0; wr_en = 1'b0;
        chk("col_done1",  16'(done1),  16'h1);
        chk("col_instr1", instr1,      16'hC0DE);
        chk("col_stall1", 16'(stall1), 16'h0);
        tick();
        chk("col_done2_l2",  16'(done), 16'h1);
        chk("col_instr2_l2", instr,     16'hBEEF);
        chk("col_done1_off", 16'(done1), 16'h0);
        req = 1'b1; addr = 16'h0006;
        tick();
        req = 1'b0;
        chk("l1_reread_done",  16'(done1), 16'h1);
        chk("l1_reread_instr", instr1,     16'hBEEF);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_mem_resp.md
Name: fetch_mem_resp

Overview:
- Instruction-memory responder on the fetch side of the pipeline.
- Accepts one fetch request at a time from the fetch stage (PC byte address) and returns the 16-bit instruction after a fixed multi-cycle latency.
- Asserts stall while a request is in flight and cancels the in-flight request when fetch redirects (branch/jump flush).
- Has a write port so the loader/testbench can program the array.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 16-bit words in the array (256 words).
- LATENCY, 2, cycles from request acceptance to the done pulse; legal range 1..15.
- NOP_INSTR, 16'h0800, value driven on instr for error responses.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  1  fetch request, sampled each cycle
- addr  input  16  byte address (PC) of requested instruction
- flush  input  1  cancels any in-flight request (redirect)
- wr_en  input  1  array write enable (loader)
- wr_addr  input  16  byte address for write
- wr_data  input  16  write data
- stall  output  1  request in flight; fetch must hold PC
- done  output  1  one-cycle pulse: instr valid
- instr  output  16  returned instruction, held until next done
- err  output  1  one-cycle pulse with done: misaligned (odd) address

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, cnt=0, stall=0, done=0, err=0, instr=16'h0000, latched address=0. Array contents are not reset.
- Index = addr[DEPTH_LOG2:1]; higher address bits are ignored (wrap-around aliasing). addr[0]=1 is misaligned.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 latches addr and sets cnt=LATENCY-1.
  - Next state is WAIT if LATENCY>1, else RESP.
  - stall=1 from the cycle after acceptance.
- WAIT:
  - stall=1; cnt decrements each cycle.
  - When cnt reaches 1, the next state is RESP.
  - The array is read at the clock edge entering RESP; instr and err are registered at that edge.
  - req is ignored while in WAIT.
- RESP (one cycle):
  - done=1, stall=0.
  - instr = mem[index], or NOP_INSTR with err=1 if the latched address is odd.
  - req=1 in this cycle is accepted (back-to-back), following the IDLE acceptance rules; otherwise next state is IDLE.
- Latency: req accepted at edge N gives done high in cycle N+LATENCY.
- flush:
  - In WAIT: return to IDLE next edge; stall=0, no done, instr unchanged.
  - In RESP: done still pulses; any req in that cycle is dropped.
  - In IDLE: a req in the same cycle is dropped.
  - flush has priority over req.
- Writes: when wr_en=1, mem[wr_addr[DEPTH_LOG2:1]] <= wr_data at the edge, independent of FSM state. A write in the same cycle as the edge entering RESP to the same index returns old data (read-before-write).
- done and err are never high outside RESP. stall and done are never high together.
- Reset asserted mid-request: immediate return to IDLE with all outputs at reset values; no done.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/RESP, 2-bit), NOP_INSTR constant, instruction width (16).
- One sub-module, fetch_mem_array: synchronous-write, combinational-read 2^DEPTH_LOG2 x 16 array with wr_en/wr_addr/wr_data and rd_index/rd_data.
- The FSM, counter and output registers live in the top module.

Test Plan:
- Basic read: write mem word 3 = 16'hC0DE via wr_addr=16'h0006; req addr=16'h0006 at edge 0 -> stall=1 in cycle 1, done=1 and instr=16'hC0DE in cycle 2, err=0.
- Back-to-back: hold req with addr 16'h0000 then 16'h0002 (word 0=16'h1111, word 1=16'h2222) -> done in cycles 2 and 4 with 16'h1111 then 16'h2222; stall never high together with done.
- Misaligned: req addr=16'h0005 -> done=1, err=1, instr=16'h0800 in cycle 2; next aligned request has err=0.
- Flush: req addr=16'h0006, flush=1 in cycle 1 -> no done pulse, stall=0 from cycle 2, instr retains its previous value.
- Async reset: rst low mid-WAIT -> stall, done, err and instr drop to 0 immediately, without waiting for a clock edge; after rst high, a new request completes normally with LATENCY=2.
- Wrap/collision: req addr=16'h0206 returns word 3 (aliasing); with LATENCY=1, a write to word 3 in the acceptance cycle returns the old value.
